gpio_apb_irq: RTL and testbench

Parametrised APB3 GPIO peripheral, the successor to the fixed 4-LED/4-button GPIO on the FX3-bridged APB bus.
- Provides GPIO_WIDTH bidirectional lines with per-bit direction control.
- Synchronises inputs and detects per-bit edge/level interrupt events into a sticky W1C status register.
- Drives a single IRQ line to the system.

---
 rtl/gpio_apb_pkg.sv | 31 +++
 rtl/gpio_apb_irq_chan.sv | 92 +++++++++
 rtl/gpio_apb_irq.sv | 160 ++++++++++++++++
 tb/tb_gpio_apb_irq.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_apb_pkg
//  Description : Shared constants for the gpio_apb_irq APB GPIO peripheral:
//                register offsets, CTRL bit index and width limits.
//  Revision    : 1.0  initial release
// ============================================================================
package gpio_apb_pkg;

  // Widest supported GPIO bank; also the APB data width
  localparam int GPIO_MAX_WIDTH = 32;

  // Width of the debounce threshold field
  localparam int DBNC_WIDTH = 16;

  // Byte offsets of the register map
  localparam logic [7:0] GPIO_CTRL   = 8'h00;
  localparam logic [7:0] GPIO_DATA   = 8'h04;
  localparam logic [7:0] GPIO_DIR    = 8'h08;
  localparam logic [7:0] GPIO_MASK   = 8'h0C;
  localparam logic [7:0] GPIO_EDGE   = 8'h10;
  localparam logic [7:0] GPIO_POL    = 8'h14;
  localparam logic [7:0] GPIO_BOTH   = 8'h18;
  localparam logic [7:0] GPIO_STATUS = 8'h1C;
  localparam logic [7:0] GPIO_DBNC   = 8'h20;

  // CTRL register: global interrupt enable bit
  localparam int CTRL_IRQ_EN_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/gpio_apb_irq_chan.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_apb_irq_chan
//  Description : One GPIO input channel: synchroniser, optional debounce
//                filter (GPIO_DEBOUNCE_EN), previous-value register, event
//                detection and sticky W1C status flop.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_apb_irq_chan
  import gpio_apb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pad_in,
  input  logic                  edge_sel,
  input  logic                  pol,
  input  logic                  both,
  input  logic                  w1c,
`ifdef GPIO_DEBOUNCE_EN
  input  logic [DBNC_WIDTH-1:0] dbnc_n,
`endif
  output logic                  value,
  output logic                  status
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic                   prev;
  logic                   evt;

  // Metastability chain: pad value shifts in at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_chain <= '0;
    else        sync_chain <= {sync_chain[SYNC_STAGES-2:0], pad_in};
  end

  assign sync = sync_chain[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic                  filt;
  logic [DBNC_WIDTH-1:0] cnt;

  // Filtered value follows sync only after N consecutive differing cycles;
  // with N=0 it tracks sync so enabling the filter later causes no glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (dbnc_n == '0 || sync == filt) begin
      filt <= sync;
      cnt  <= '0;
    end else if (cnt == dbnc_n - 16'd1) begin
      filt <= sync;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 16'd1;
    end
  end

  assign value = (dbnc_n == '0) ? sync : filt;
`else
  assign value = sync;
`endif

  // Previous value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= value;
  end

  // Event: both edges, single polarity edge, or level match
  always_comb begin
    evt = 1'b0;
    if (edge_sel) begin
      if (both)     evt = value ^ prev;
      else if (pol) evt = value & ~prev;
      else          evt = ~value & prev;
    end else begin
      evt = (value == pol);
    end
  end

  // Sticky status; a new event wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status <= 1'b0;
    else        status <= evt | (status & ~w1c);
  end

endmodule
`default_nettype wire

// File: rtl/gpio_apb_irq.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_apb_irq
//  Description : Parametrised APB3 GPIO with per-bit direction, edge/level
//                interrupt events, sticky W1C status and a registered IRQ.
//                Optional input debounce filter enabled by GPIO_DEBOUNCE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_apb_irq
  import gpio_apb_pkg::*;
#(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [GPIO_WIDTH-1:0] GPIO_I,
  output logic [GPIO_WIDTH-1:0] GPIO_O,
  output logic [GPIO_WIDTH-1:0] GPIO_T,
  output logic                  IRQ
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(GPIO_CTRL);
  localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(GPIO_DATA);
  localparam logic [ADDR_WIDTH-1:0] A_DIR    = ADDR_WIDTH'(GPIO_DIR);
  localparam logic [ADDR_WIDTH-1:0] A_MASK   = ADDR_WIDTH'(GPIO_MASK);
  localparam logic [ADDR_WIDTH-1:0] A_EDGE   = ADDR_WIDTH'(GPIO_EDGE);
  localparam logic [ADDR_WIDTH-1:0] A_POL    = ADDR_WIDTH'(GPIO_POL);
  localparam logic [ADDR_WIDTH-1:0] A_BOTH   = ADDR_WIDTH'(GPIO_BOTH);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(GPIO_STATUS);
  localparam logic [ADDR_WIDTH-1:0] A_DBNC   = ADDR_WIDTH'(GPIO_DBNC);

  logic                  ctrl_irq_en;
  logic [GPIO_WIDTH-1:0] mask;
  logic [GPIO_WIDTH-1:0] edge_mode;
  logic [GPIO_WIDTH-1:0] pol;
  logic [GPIO_WIDTH-1:0] both;
  logic [GPIO_WIDTH-1:0] in_value;
  logic [GPIO_WIDTH-1:0] status;
  logic [GPIO_WIDTH-1:0] w1c;
`ifdef GPIO_DEBOUNCE_EN
  logic [DBNC_WIDTH-1:0] dbnc_n;
`endif

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  unmapped;
  logic                  wr_en;
  logic                  rd_setup;
  logic [31:0]           rdata;
  logic                  unused_addr_bits;

  // Byte lanes are not decoded
  assign word_addr        = {PADDR[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr_bits = ^PADDR[1:0];

`ifdef GPIO_DEBOUNCE_EN
  assign unmapped = (word_addr > A_DBNC);
`else
  assign unmapped = (word_addr > A_STATUS);
`endif

  assign wr_en    = PSEL & PENABLE & PWRITE & ~unmapped;
  assign rd_setup = PSEL & ~PENABLE & ~PWRITE;
  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL & PENABLE & unmapped;
  assign w1c      = (wr_en && word_addr == A_STATUS) ? PWDATA[GPIO_WIDTH-1:0] : '0;

  // Configuration registers, committed in the APB access phase
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_irq_en <= 1'b0;
      GPIO_O      <= '0;
      GPIO_T      <= '0;
      mask        <= '0;
      edge_mode   <= '0;
      pol         <= '0;
      both        <= '0;
`ifdef GPIO_DEBOUNCE_EN
      dbnc_n      <= '0;
`endif
    end else if (wr_en) begin
      case (word_addr)
        A_CTRL:  ctrl_irq_en <= PWDATA[CTRL_IRQ_EN_BIT];
        A_DATA:  GPIO_O      <= PWDATA[GPIO_WIDTH-1:0];
        A_DIR:   GPIO_T      <= PWDATA[GPIO_WIDTH-1:0];
        A_MASK:  mask        <= PWDATA[GPIO_WIDTH-1:0];
        A_EDGE:  edge_mode   <= PWDATA[GPIO_WIDTH-1:0];
        A_POL:   pol         <= PWDATA[GPIO_WIDTH-1:0];
        A_BOTH:  both        <= PWDATA[GPIO_WIDTH-1:0];
`ifdef GPIO_DEBOUNCE_EN
        A_DBNC:  dbnc_n      <= PWDATA[DBNC_WIDTH-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Read mux; unmapped offsets and bits above GPIO_WIDTH return 0
  always_comb begin
    rdata = '0;
    if (!unmapped) begin
      case (word_addr)
        A_CTRL:   rdata[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
        A_DATA:   rdata = 32'(in_value);
        A_DIR:    rdata = 32'(GPIO_T);
        A_MASK:   rdata = 32'(mask);
        A_EDGE:   rdata = 32'(edge_mode);
        A_POL:    rdata = 32'(pol);
        A_BOTH:   rdata = 32'(both);
        A_STATUS: rdata = 32'(status);
`ifdef GPIO_DEBOUNCE_EN
        A_DBNC:   rdata = 32'(dbnc_n);
`endif
        default:  rdata = '0;
      endcase
    end
  end

  // Read data captured in the setup phase, held otherwise
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)      PRDATA <= '0;
    else if (rd_setup) PRDATA <= rdata;
  end

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_chan
    gpio_apb_irq_chan #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .pad_in  (GPIO_I[i]),
      .edge_sel(edge_mode[i]),
      .pol     (pol[i]),
      .both    (both[i]),
      .w1c     (w1c[i]),
`ifdef GPIO_DEBOUNCE_EN
      .dbnc_n  (dbnc_n),
`endif
      .value   (in_value[i]),
      .status  (status[i])
    );
  end

  // Registered interrupt: any masked pending event while globally enabled
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) IRQ <= 1'b0;
    else          IRQ <= ctrl_irq_en & (|(status & mask));
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_apb_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_apb_irq
//  Description : Self-checking bench for gpio_apb_irq: directed register,
//                interrupt, error and debounce steps followed by random
//                traffic compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gpio_apb_irq;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int AW = 8;

  logic          PCLK    = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE  = 1'b0;
  logic [AW-1:0] PADDR   = '0;
  logic [31:0]   PWDATA  = '0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [W-1:0]  GPIO_I  = '0;
  logic [W-1:0]  GPIO_O;
  logic [W-1:0]  GPIO_T;
  logic          IRQ;

  int n_chk  = 0;
  int n_fail = 0;
  bit rand_phase = 1'b0;

  gpio_apb_irq #(
    .GPIO_WIDTH (W),
    .SYNC_STAGES(SS),
    .ADDR_WIDTH (AW)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .GPIO_I (GPIO_I),
    .GPIO_O (GPIO_O),
    .GPIO_T (GPIO_T),
    .IRQ    (IRQ)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- behavioural reference model ----------------
  // hist[k] is the pad value sampled k+1 edges ago; sync is SS edges old
  logic [31:0] m_hist [0:SS];
  logic [31:0] m_status = '0, m_data = '0, m_dir = '0, m_mask = '0;
  logic [31:0] m_edge = '0, m_pol = '0, m_both = '0, m_dbnc = '0, m_prdata = '0;
  logic        m_ctrl = 1'b0, m_irq = 1'b0;

  initial for (int k = 0; k <= SS; k++) m_hist[k] = '0;

  function automatic logic [31:0] events(input logic [31:0] s, input logic [31:0] p);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < W; i++) begin
      if (!m_edge[i])     e[i] = (s[i] == m_pol[i]);
      else if (m_both[i]) e[i] = (s[i] != p[i]);
      else if (m_pol[i])  e[i] = (s[i] && !p[i]);
      else                e[i] = (!s[i] && p[i]);
    end
    return e;
  endfunction

  function automatic logic [31:0] rd_model(input logic [AW-1:0] a);
    case (a & 8'hFC)
      8'h00:   return {31'b0, m_ctrl};
      8'h04:   return m_hist[SS-1];
      8'h08:   return m_dir;
      8'h0C:   return m_mask;
      8'h10:   return m_edge;
      8'h14:   return m_pol;
      8'h18:   return m_both;
      8'h1C:   return m_status;
`ifdef GPIO_DEBOUNCE_EN
      8'h20:   return m_dbnc;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] w1c_now();
    if (PSEL && PENABLE && PWRITE && ((PADDR & 8'hFC) == 8'h1C)) return PWDATA;
    return '0;
  endfunction

  // Model state advances on the same edges the design sees
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k <= SS; k++) m_hist[k] <= '0;
      m_status <= '0; m_data <= '0; m_dir <= '0; m_mask <= '0;
      m_edge <= '0; m_pol <= '0; m_both <= '0; m_dbnc <= '0;
      m_prdata <= '0; m_ctrl <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_hist[0] <= GPIO_I;
      for (int k = 1; k <= SS; k++) m_hist[k] <= m_hist[k-1];
      m_status <= events(m_hist[SS-1], m_hist[SS]) | (m_status & ~w1c_now());
      m_irq    <= m_ctrl & (|(m_status & m_mask));
      if (PSEL && !PENABLE && !PWRITE) m_prdata <= rd_model(PADDR);
      if (PSEL && PENABLE && PWRITE) begin
        case (PADDR & 8'hFC)
          8'h00: m_ctrl <= PWDATA[0];
          8'h04: m_data <= PWDATA;
          8'h08: m_dir  <= PWDATA;
          8'h0C: m_mask <= PWDATA;
          8'h10: m_edge <= PWDATA;
          8'h14: m_pol  <= PWDATA;
          8'h18: m_both <= PWDATA;
`ifdef GPIO_DEBOUNCE_EN
          8'h20: m_dbnc <= {16'b0, PWDATA[15:0]};
`endif
          default: ;
        endcase
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    if (rand_phase) begin
      check("rand_irq", {31'b0, IRQ}, {31'b0, m_irq});
      check("rand_gpio_o", GPIO_O, m_data);
      check("rand_gpio_t", GPIO_T, m_dir);
    end
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d, output logic err);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    #1;
    d   = PRDATA;
    err = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    logic [AW-1:0] a;
    logic [31:0] d;
    int unsigned r;

    // Reset values
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_gpio_o", GPIO_O, 32'h0);
    check("rst_gpio_t", GPIO_T, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("pready", {31'b0, PREADY}, 32'h1);
    PRESETn = 1'b1;
    tick();

    // DIR readback
    apb_write(8'h08, 32'hA5A5A5A5);
    check("dir_gpio_t", GPIO_T, 32'hA5A5A5A5);
    apb_read(8'h08, rd, er);
    check("dir_read", rd, 32'hA5A5A5A5);
    check("dir_read_err", {31'b0, er}, 32'h0);

    // Reset asserted in the middle of a DIR write
    PADDR = 8'h08; PWDATA = 32'h12345678; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    check("midrst_gpio_t", GPIO_T, 32'h0);
    check("midrst_gpio_o", GPIO_O, 32'h0);
    check("midrst_irq", {31'b0, IRQ}, 32'h0);
    check("midrst_prdata", PRDATA, 32'h0);
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PRESETn = 1'b1;
    tick();
    apb_read(8'h08, rd, er);
    check("midrst_dir_read", rd, 32'h0);

    // Output path
    apb_write(8'h08, 32'h0000000F);
    apb_write(8'h04, 32'h00000005);
    check("out_gpio_o", GPIO_O, 32'h5);
    check("out_gpio_t", GPIO_T, 32'hF);

    // Rising-edge interrupt on bit 0
    apb_write(8'h10, 32'hFFFFFFFF);
    apb_write(8'h14, 32'hFFFFFFFF);
    apb_write(8'h18, 32'h0);
    apb_write(8'h1C, 32'hFFFFFFFF);
    apb_write(8'h0C, 32'h1);
    apb_write(8'h00, 32'h1);
    apb_read(8'h1C, rd, er);
    check("irq_status_clean", rd, 32'h0);
    GPIO_I[0] = 1'b1;
    tick(); tick();
    check("irq_e2", {31'b0, IRQ}, 32'h0);
    tick();
    check("irq_e3", {31'b0, IRQ}, 32'h0);
    tick();
    check("irq_e4", {31'b0, IRQ}, 32'h1);
    apb_read(8'h1C, rd, er);
    check("rise_status", rd, 32'h1);
    apb_write(8'h1C, 32'h1);
    check("w1c_irq_same", {31'b0, IRQ}, 32'h1);
    tick();
    check("w1c_irq_drop", {31'b0, IRQ}, 32'h0);
    apb_read(8'h1C, rd, er);
    check("w1c_status", rd, 32'h0);

    // Both edges on bit 1
    apb_write(8'h18, 32'h2);
    GPIO_I[1] = 1'b1;
    repeat (4) tick();
    apb_read(8'h1C, rd, er);
    check("both_rise", rd, 32'h2);
    apb_write(8'h1C, 32'h2);
    apb_read(8'h1C, rd, er);
    check("both_clr1", rd, 32'h0);
    GPIO_I[1] = 1'b0;
    repeat (4) tick();
    apb_read(8'h1C, rd, er);
    check("both_fall", rd, 32'h2);
    apb_write(8'h1C, 32'h2);
    apb_read(8'h1C, rd, er);
    check("both_clr2", rd, 32'h0);

    // Active-low level on bit 2 re-asserts after clear
    apb_write(8'h10, 32'hFFFFFFFB);
    apb_write(8'h14, 32'hFFFFFFFB);
    repeat (2) tick();
    apb_read(8'h1C, rd, er);
    check("level_set", rd, 32'h4);
    apb_write(8'h1C, 32'h4);
    apb_read(8'h1C, rd, er);
    check("level_reassert", rd, 32'h4);
    GPIO_I[2] = 1'b1;
    repeat (4) tick();
    apb_write(8'h1C, 32'hFFFFFFFF);
    apb_read(8'h1C, rd, er);
    check("level_gone", rd, 32'h0);

    // Set wins over a W1C landing on the same edge
    GPIO_I[0] = 1'b0;
    repeat (4) tick();
    GPIO_I[0] = 1'b1;
    tick();
    apb_write(8'h1C, 32'h1);
    apb_read(8'h1C, rd, er);
    check("collision", rd, 32'h1);
    apb_write(8'h1C, 32'h1);

    // Unmapped offsets
    apb_read(8'h24, rd, er);
    check("err24_flag", {31'b0, er}, 32'h1);
    check("err24_data", rd, 32'h0);
    apb_read(8'h3C, rd, er);
    check("err3c_flag", {31'b0, er}, 32'h1);
`ifdef GPIO_DEBOUNCE_EN
    apb_write(8'h20, 32'h4);
    apb_read(8'h20, rd, er);
    check("dbnc_flag", {31'b0, er}, 32'h0);
    check("dbnc_read", rd, 32'h4);
    apb_write(8'h1C, 32'hFFFFFFFF);
    GPIO_I[3] = 1'b1;
    repeat (3) tick();
    GPIO_I[3] = 1'b0;
    repeat (10) tick();
    apb_read(8'h1C, rd, er);
    check("dbnc_glitch", rd, 32'h0);
    GPIO_I[3] = 1'b1;
    repeat (6) tick();
    GPIO_I[3] = 1'b0;
    repeat (10) tick();
    apb_read(8'h1C, rd, er);
    check("dbnc_pulse", rd, 32'h8);
    apb_write(8'h20, 32'h0);
`else
    apb_write(8'h20, 32'h4);
    apb_read(8'h20, rd, er);
    check("err20_flag", {31'b0, er}, 32'h1);
    check("err20_data", rd, 32'h0);
`endif

    // Random traffic against the reference model from a clean reset
    PRESETn = 1'b0;
    #2 PRESETn = 1'b1;
    GPIO_I = '0;
    tick();
    rand_phase = 1'b1;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        GPIO_I = GPIO_I ^ ($urandom & $urandom & $urandom);
        tick();
      end else if (r < 8) begin
        a = 8'($urandom_range(0, 7) * 4);
        d = $urandom;
        if (a == 8'h00) d = {31'b0, d[0] | d[1]};
        apb_write(a, d);
      end else begin
        a = 8'($urandom_range(0, 7) * 4);
        apb_read(a, rd, er);
        check("rand_read", rd, m_prdata);
        check("rand_read_err", {31'b0, er}, 32'h0);
      end
    end
    rand_phase = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
